display_scan_ctrl: RTL and testbench

Time-multiplexing scan controller for the microwave's three-digit M:SS display. It shares one BCD-to-7-segment decoder between the minutes, tens-of-seconds and seconds digits. It snapshots the timer's BCD digits on a load strobe and rotates one digit per slot onto the shared decoder input. It also drives active-low digit enables with anti-ghosting dead time, leading-zero blanking and a blink mode for the "cook done" indication.

---
 rtl/display_scan_ctrl.sv | 151 +++++++++++++++
 tb/tb_display_scan_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: time-multiplexed scan controller for a three-digit M:SS display.
// One BCD-to-7-segment decoder is shared between the minutes, tens-of-seconds and
// seconds digits. Timer digits are snapshotted on Load, and one digit is shown per slot.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   Min        BCD minutes digit
//   TenSec     BCD tens-of-seconds digit
//   Sec        BCD seconds digit
//   Load       snapshot strobe for Min/TenSec/Sec
//   Blink      level, enables whole-display blinking
//   LzBlank    level, blanks the minutes digit when its snapshot is 0
//   DigitBcd   BCD to the shared decoder (4'hF = blank)
//   DigitSel   active-low one-hot digit enables {Min, TenSec, Sec}
//   FrameTick  one-clock pulse in the last cycle of the Sec slot
module display_scan_ctrl #(
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned DEAD_CYC     = 4,
  parameter int unsigned BLINK_FRAMES = 128
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] Min,
  input  logic [3:0] TenSec,
  input  logic [3:0] Sec,
  input  logic       Load,
  input  logic       Blink,
  input  logic       LzBlank,
  output logic [3:0] DigitBcd,
  output logic [2:0] DigitSel,
  output logic       FrameTick
);

  localparam int unsigned KW = $clog2(SCAN_DIV);
  localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [KW-1:0] KLast    = KW'(SCAN_DIV - 1);
  localparam logic [KW-1:0] KTickPre = KW'(SCAN_DIV - 2);
  localparam logic [KW-1:0] KDead    = KW'(DEAD_CYC);
  localparam logic [FW-1:0] FLast    = FW'(BLINK_FRAMES - 1);

  localparam logic [3:0] BlankCode = 4'hF;
  localparam logic [2:0] SelNone   = 3'b111;

  typedef enum logic [1:0] {StMin, StTen, StSec} state_e;

  state_e        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [3:0]    sh_min_q, sh_min_d;
  logic [3:0]    sh_ten_q, sh_ten_d;
  logic [3:0]    sh_sec_q, sh_sec_d;
  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic          phase_q, phase_d;  // 1 = blink phase ON
  logic [3:0]    digit_bcd_q, digit_bcd_d;
  logic [2:0]    digit_sel_q, digit_sel_d;
  logic          frame_tick_q, frame_tick_d;
  logic          phase_on;

  always_comb begin
    // Slot prescaler and digit rotation
    k_d     = (k_q == KLast) ? '0 : k_q + KW'(1);
    state_d = state_q;
    if (k_q == KLast) begin
      case (state_q)
        StMin:   state_d = StTen;
        StTen:   state_d = StSec;
        StSec:   state_d = StMin;
        default: state_d = StMin;
      endcase
    end

    // Shadow snapshot, independent of scan position
    sh_min_d = Load ? Min    : sh_min_q;
    sh_ten_d = Load ? TenSec : sh_ten_q;
    sh_sec_d = Load ? Sec    : sh_sec_q;

    // Blink: held at count 0 / phase ON while disabled, so enabling starts ON
    frame_cnt_d = frame_cnt_q;
    phase_d     = phase_q;
    if (!Blink) begin
      frame_cnt_d = '0;
      phase_d     = 1'b1;
    end else if (frame_tick_q) begin
      if (frame_cnt_q == FLast) begin
        frame_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + FW'(1);
      end
    end

    // Blink=0 must restore enables on the very next clock, ahead of phase_q
    phase_on = phase_q | ~Blink;

    digit_sel_d = SelNone;
    if ((k_q >= KDead) && phase_on) begin
      case (state_q)
        StMin:   digit_sel_d = 3'b011;
        StTen:   digit_sel_d = 3'b101;
        StSec:   digit_sel_d = 3'b110;
        default: digit_sel_d = SelNone;
      endcase
    end

    // Digit is latched only at slot start, so mid-slot loads cannot tear
    digit_bcd_d = digit_bcd_q;
    if (k_q == '0) begin
      case (state_q)
        StMin:   digit_bcd_d = (LzBlank && (sh_min_q == 4'd0)) ? BlankCode : sh_min_q;
        StTen:   digit_bcd_d = sh_ten_q;
        StSec:   digit_bcd_d = sh_sec_q;
        default: digit_bcd_d = BlankCode;
      endcase
    end

    // Registered, so decode one cycle early to land on the last Sec cycle
    frame_tick_d = (state_q == StSec) && (k_q == KTickPre);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StMin;
      k_q          <= '0;
      sh_min_q     <= 4'd0;
      sh_ten_q     <= 4'd0;
      sh_sec_q     <= 4'd0;
      frame_cnt_q  <= '0;
      phase_q      <= 1'b1;
      digit_bcd_q  <= BlankCode;
      digit_sel_q  <= SelNone;
      frame_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      sh_min_q     <= sh_min_d;
      sh_ten_q     <= sh_ten_d;
      sh_sec_q     <= sh_sec_d;
      frame_cnt_q  <= frame_cnt_d;
      phase_q      <= phase_d;
      digit_bcd_q  <= digit_bcd_d;
      digit_sel_q  <= digit_sel_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign DigitBcd  = digit_bcd_q;
  assign DigitSel  = digit_sel_q;
  assign FrameTick = frame_tick_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with SCAN_DIV=8, DEAD_CYC=2, BLINK_FRAMES=2.
// Edge numbers in comments count rising edges since the most recent reset release;
// after edge n the registered outputs reflect scan position n-1.
module tb_display_scan_ctrl;

  logic       clk;
  logic       rst_n;
  logic [3:0] Min, TenSec, Sec;
  logic       Load, Blink, LzBlank;
  logic [3:0] DigitBcd;
  logic [2:0] DigitSel;
  logic       FrameTick;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  display_scan_ctrl #(
    .SCAN_DIV    (8),
    .DEAD_CYC    (2),
    .BLINK_FRAMES(2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .Min      (Min),
    .TenSec   (TenSec),
    .Sec      (Sec),
    .Load     (Load),
    .Blink    (Blink),
    .LzBlank  (LzBlank),
    .DigitBcd (DigitBcd),
    .DigitSel (DigitSel),
    .FrameTick(FrameTick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    total_cnt++;
    assert (got === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; Min = 4'd1; TenSec = 4'd2; Sec = 4'd3;
    Load = 1'b0; Blink = 1'b0; LzBlank = 1'b0;

    // Reset state
    step(2);
    chk("rst_sel",  {1'b0, DigitSel}, 4'b0111);
    chk("rst_bcd",  DigitBcd, 4'hF);
    chk("rst_tick", {3'b0, FrameTick}, 4'd0);

    // Release with Load for one cycle
    rst_n = 1'b1; Load = 1'b1;
    step(1);                                            // e1: MIN k0, old shadow
    Load = 1'b0;
    chk("first_bcd", DigitBcd, 4'd0);
    chk("first_sel_dead", {1'b0, DigitSel}, 4'b0111);
    step(2);                                            // e3
    chk("min_sel", {1'b0, DigitSel}, 4'b0011);
    step(5);                                            // e8: MIN k7
    chk("min_sel_k7", {1'b0, DigitSel}, 4'b0011);
    step(1);                                            // e9: TEN k0
    chk("ten_bcd", DigitBcd, 4'd2);
    chk("ten_sel_dead", {1'b0, DigitSel}, 4'b0111);
    step(2);                                            // e11
    chk("ten_sel", {1'b0, DigitSel}, 4'b0101);
    step(6);                                            // e17: SEC k0
    chk("sec_bcd", DigitBcd, 4'd3);
    chk("sec_sel_dead", {1'b0, DigitSel}, 4'b0111);
    step(2);                                            // e19
    chk("sec_sel", {1'b0, DigitSel}, 4'b0110);
    step(3);                                            // e22
    chk("tick_low", {3'b0, FrameTick}, 4'd0);
    step(1);                                            // e23
    chk("tick_high", {3'b0, FrameTick}, 4'd1);
    step(1);                                            // e24
    chk("tick_pulse", {3'b0, FrameTick}, 4'd0);
    chk("sec_sel_k7", {1'b0, DigitSel}, 4'b0110);
    step(1);                                            // e25: MIN again
    chk("min_bcd", DigitBcd, 4'd1);
    step(22);                                           // e47
    chk("tick_high2", {3'b0, FrameTick}, 4'd1);

    // Tearing: load Min=7 mid MIN slot
    step(4);                                            // e51
    Min = 4'd7; Load = 1'b1;
    step(1);                                            // e52
    Load = 1'b0;
    chk("tear_hold", DigitBcd, 4'd1);
    step(20);                                           // e72: SEC slot
    chk("tear_sec", DigitBcd, 4'd3);
    step(1);                                            // e73: MIN slot start
    chk("tear_new", DigitBcd, 4'd7);

    // Leading-zero blanking
    Min = 4'd0; Load = 1'b1; LzBlank = 1'b1;
    step(1);                                            // e74
    Load = 1'b0;
    step(23);                                           // e97
    chk("lz_bcd", DigitBcd, 4'hF);
    step(2);                                            // e99
    chk("lz_sel", {1'b0, DigitSel}, 4'b0011);
    chk("lz_bcd_hold", DigitBcd, 4'hF);
    LzBlank = 1'b0;
    step(22);                                           // e121
    chk("nolz_bcd", DigitBcd, 4'd0);
    step(2);                                            // e123
    chk("nolz_sel", {1'b0, DigitSel}, 4'b0011);

    // Blink: ON until edge 168, OFF until 216, ON until 264
    Blink = 1'b1;
    step(32);                                           // e155
    chk("blink_on", {1'b0, DigitSel}, 4'b0101);
    step(16);                                           // e171
    chk("blink_off_sel", {1'b0, DigitSel}, 4'b0111);
    chk("blink_off_bcd", DigitBcd, 4'd0);
    step(9);                                            // e180
    chk("blink_off_sel2", {1'b0, DigitSel}, 4'b0111);
    chk("blink_off_bcd2", DigitBcd, 4'd2);
    step(32);                                           // e212
    chk("blink_off_sel3", {1'b0, DigitSel}, 4'b0111);
    chk("blink_off_bcd3", DigitBcd, 4'd3);
    step(7);                                            // e219
    chk("blink_on2", {1'b0, DigitSel}, 4'b0011);
    step(48);                                           // e267
    chk("blink_off4", {1'b0, DigitSel}, 4'b0111);
    Blink = 1'b0;
    step(1);                                            // e268
    chk("blink_restore", {1'b0, DigitSel}, 4'b0011);

    // Invalid BCD passes through
    Sec = 4'hC; Load = 1'b1;
    step(1);                                            // e269
    Load = 1'b0;
    step(12);                                           // e281
    chk("inv_bcd", DigitBcd, 4'hC);
    step(2);                                            // e283
    chk("inv_sel", {1'b0, DigitSel}, 4'b0110);

    // Asynchronous reset mid TEN slot
    step(18);                                           // e301: counter at TEN k5
    chk("pre_rst_sel", {1'b0, DigitSel}, 4'b0101);
    rst_n = 1'b0;
    #1;
    chk("async_sel", {1'b0, DigitSel}, 4'b0111);
    chk("async_bcd", DigitBcd, 4'hF);
    #1;
    rst_n = 1'b1;
    step(1);                                            // e1 after release
    chk("rst2_bcd", DigitBcd, 4'd0);
    chk("rst2_sel", {1'b0, DigitSel}, 4'b0111);
    step(2);                                            // e3
    chk("rst2_min_sel", {1'b0, DigitSel}, 4'b0011);
    step(6);                                            // e9: TEN, shadow reset
    chk("rst2_ten_bcd", DigitBcd, 4'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
